// File: rtl/lift_sched.sv
// ---------------------------------------------------------------------------
// lift_sched: SCAN elevator scheduler for FLOORS floors.
// Cabin and hall requests are latched per floor. The cabin keeps its travel
// direction while work remains ahead of it, and reverses only when nothing is
// pending in the current direction. Each floor takes MOVE_CYC cycles to
// travel. The door stays open for DOOR_CYC cycles. A press at the current
// floor while the door is open restarts the door timer.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   car_req_i    cabin buttons, one bit per floor
//   hall_up_i    hall "up" buttons (top floor bit ignored)
//   hall_dn_i    hall "down" buttons (floor 0 bit ignored)
//   elev_f_o     current cabin floor
//   dir_o        00 none, 01 up, 10 down
//   door_open_o  door open
//   busy_o       controller not idle
//   pend_o       pending requests per floor (car | up | dn)
// ---------------------------------------------------------------------------
module lift_sched #(
  parameter int FLOORS   = 8,
  parameter int FLOOR_W  = 3,
  parameter int MOVE_CYC = 4,
  parameter int DOOR_CYC = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FLOORS-1:0]  car_req_i,
  input  logic [FLOORS-1:0]  hall_up_i,
  input  logic [FLOORS-1:0]  hall_dn_i,
  output logic [FLOOR_W-1:0] elev_f_o,
  output logic [1:0]         dir_o,
  output logic               door_open_o,
  output logic               busy_o,
  output logic [FLOORS-1:0]  pend_o
);

  localparam int CNT_MAX = (MOVE_CYC > DOOR_CYC) ? MOVE_CYC : DOOR_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [FLOORS-1:0]  ONE_HOT0 = {{(FLOORS-1){1'b0}}, 1'b1};
  localparam logic [FLOORS-1:0]  UP_MASK  = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0]  DN_MASK  = {{(FLOORS-1){1'b1}}, 1'b0};
  localparam logic [FLOOR_W-1:0] TOP_F    = FLOOR_W'(FLOORS - 1);
  localparam logic [CNT_W-1:0]   MOVE_END = CNT_W'(MOVE_CYC - 1);
  localparam logic [CNT_W-1:0]   DOOR_END = CNT_W'(DOOR_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MOVE = 2'b01,
    ST_DOOR = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DN   = 2'b10
  } dir_t;

  state_t               state_r;
  dir_t                 dir_r;
  logic [FLOOR_W-1:0]   cur_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [FLOORS-1:0]    car_p_r;
  logic [FLOORS-1:0]    up_p_r;
  logic [FLOORS-1:0]    dn_p_r;
  logic                 door_open_r;
  logic                 busy_r;

  logic [FLOORS-1:0]    car_in_s;
  logic [FLOORS-1:0]    up_in_s;
  logic [FLOORS-1:0]    dn_in_s;
  logic [FLOORS-1:0]    pend_s;
  logic [FLOORS-1:0]    cur_oh_s;
  logic [FLOORS-1:0]    nxt_oh_s;
  logic [FLOOR_W-1:0]   nxt_f_s;
  logic                 above_s;
  logic                 below_s;
  logic                 here_s;
  logic                 beyond_s;
  logic                 stop_s;
  logic                 move_done_s;
  logic                 door_done_s;
  logic                 press_here_s;
  logic [FLOORS-1:0]    clr_car_s;
  logic [FLOORS-1:0]    clr_up_s;
  logic [FLOORS-1:0]    clr_dn_s;
  logic [FLOORS-1:0]    absorb_s;

  // Any pending bit strictly above floor f.
  function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      r = r | (p[i] & (i > int'(f)));
    end
    return r;
  endfunction

  // Any pending bit strictly below floor f.
  function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      r = r | (p[i] & (i < int'(f)));
    end
    return r;
  endfunction

  // Request summary, arrival floor and stop decision from registered state.
  always_comb begin
    car_in_s     = car_req_i;
    up_in_s      = hall_up_i & UP_MASK;
    dn_in_s      = hall_dn_i & DN_MASK;
    pend_s       = car_p_r | up_p_r | dn_p_r;
    cur_oh_s     = ONE_HOT0 << cur_r;
    above_s      = any_above(pend_s, cur_r);
    below_s      = any_below(pend_s, cur_r);
    here_s       = |(pend_s & cur_oh_s);
    move_done_s  = (cnt_r == MOVE_END);
    door_done_s  = (cnt_r == DOOR_END);
    press_here_s = |((car_in_s | up_in_s | dn_in_s) & cur_oh_s);

    // Floor arithmetic saturates at both ends of the shaft.
    if ((dir_r == DIR_UP) && (cur_r != TOP_F)) begin
      nxt_f_s = cur_r + FLOOR_W'(1);
    end else if ((dir_r == DIR_DN) && (cur_r != {FLOOR_W{1'b0}})) begin
      nxt_f_s = cur_r - FLOOR_W'(1);
    end else begin
      nxt_f_s = cur_r;
    end
    nxt_oh_s = ONE_HOT0 << nxt_f_s;

    if (dir_r == DIR_UP) begin
      beyond_s = any_above(pend_s, nxt_f_s);
      stop_s   = (|(car_p_r & nxt_oh_s)) | (|(up_p_r & nxt_oh_s)) | ~beyond_s;
    end else if (dir_r == DIR_DN) begin
      beyond_s = any_below(pend_s, nxt_f_s);
      stop_s   = (|(car_p_r & nxt_oh_s)) | (|(dn_p_r & nxt_oh_s)) | ~beyond_s;
    end else begin
      beyond_s = 1'b0;
      stop_s   = 1'b1;
    end
  end

  // Which pending bits are served this cycle, and which presses are absorbed.
  always_comb begin
    clr_car_s = {FLOORS{1'b0}};
    clr_up_s  = {FLOORS{1'b0}};
    clr_dn_s  = {FLOORS{1'b0}};
    absorb_s  = {FLOORS{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (here_s) begin
          clr_car_s = cur_oh_s;
          clr_up_s  = cur_oh_s;
          clr_dn_s  = cur_oh_s;
        end else begin
          clr_car_s = {FLOORS{1'b0}};
        end
      end
      ST_MOVE: begin
        if (move_done_s && stop_s) begin
          clr_car_s = nxt_oh_s;
          // Same-direction hall call is served; the opposite one only when
          // the cabin will turn around here anyway.
          if (dir_r == DIR_UP) begin
            clr_up_s = nxt_oh_s;
            clr_dn_s = beyond_s ? {FLOORS{1'b0}} : nxt_oh_s;
          end else if (dir_r == DIR_DN) begin
            clr_dn_s = nxt_oh_s;
            clr_up_s = beyond_s ? {FLOORS{1'b0}} : nxt_oh_s;
          end else begin
            clr_up_s = nxt_oh_s;
            clr_dn_s = nxt_oh_s;
          end
        end else begin
          clr_car_s = {FLOORS{1'b0}};
        end
      end
      ST_DOOR: begin
        absorb_s = cur_oh_s;
        // Directionless expiry re-applies the idle rules, including "here".
        if (door_done_s && !press_here_s && (dir_r == DIR_NONE) && here_s) begin
          clr_car_s = cur_oh_s;
          clr_up_s  = cur_oh_s;
          clr_dn_s  = cur_oh_s;
        end else begin
          clr_car_s = {FLOORS{1'b0}};
        end
      end
      default: begin
        absorb_s = {FLOORS{1'b0}};
      end
    endcase
  end

  // Scheduler FSM, counters, pending registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      dir_r       <= DIR_NONE;
      cur_r       <= {FLOOR_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      car_p_r     <= {FLOORS{1'b0}};
      up_p_r      <= {FLOORS{1'b0}};
      dn_p_r      <= {FLOORS{1'b0}};
      door_open_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      car_p_r <= (car_p_r | (car_in_s & ~absorb_s)) & ~clr_car_s;
      up_p_r  <= (up_p_r  | (up_in_s  & ~absorb_s)) & ~clr_up_s;
      dn_p_r  <= (dn_p_r  | (dn_in_s  & ~absorb_s)) & ~clr_dn_s;

      case (state_r)
        ST_IDLE: begin
          cnt_r <= {CNT_W{1'b0}};
          if (here_s) begin
            state_r     <= ST_DOOR;
            dir_r       <= DIR_NONE;
            door_open_r <= 1'b1;
            busy_r      <= 1'b1;
          end else if (above_s) begin
            state_r <= ST_MOVE;
            dir_r   <= DIR_UP;
            busy_r  <= 1'b1;
          end else if (below_s) begin
            state_r <= ST_MOVE;
            dir_r   <= DIR_DN;
            busy_r  <= 1'b1;
          end else begin
            dir_r  <= DIR_NONE;
            busy_r <= 1'b0;
          end
        end

        ST_MOVE: begin
          if (move_done_s) begin
            cur_r <= nxt_f_s;
            cnt_r <= {CNT_W{1'b0}};
            if (stop_s) begin
              state_r     <= ST_DOOR;
              door_open_r <= 1'b1;
            end else begin
              state_r <= ST_MOVE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        ST_DOOR: begin
          if (press_here_s) begin
            cnt_r <= {CNT_W{1'b0}};
          end else if (door_done_s) begin
            cnt_r <= {CNT_W{1'b0}};
            if ((dir_r == DIR_UP) && above_s) begin
              state_r     <= ST_MOVE;
              door_open_r <= 1'b0;
            end else if ((dir_r == DIR_DN) && below_s) begin
              state_r     <= ST_MOVE;
              door_open_r <= 1'b0;
            end else if ((dir_r == DIR_UP) && below_s) begin
              state_r     <= ST_MOVE;
              dir_r       <= DIR_DN;
              door_open_r <= 1'b0;
            end else if ((dir_r == DIR_DN) && above_s) begin
              state_r     <= ST_MOVE;
              dir_r       <= DIR_UP;
              door_open_r <= 1'b0;
            end else if ((dir_r == DIR_NONE) && here_s) begin
              state_r <= ST_DOOR;
            end else if ((dir_r == DIR_NONE) && above_s) begin
              state_r     <= ST_MOVE;
              dir_r       <= DIR_UP;
              door_open_r <= 1'b0;
            end else if ((dir_r == DIR_NONE) && below_s) begin
              state_r     <= ST_MOVE;
              dir_r       <= DIR_DN;
              door_open_r <= 1'b0;
            end else begin
              state_r     <= ST_IDLE;
              dir_r       <= DIR_NONE;
              door_open_r <= 1'b0;
              busy_r      <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          dir_r       <= DIR_NONE;
          cnt_r       <= {CNT_W{1'b0}};
          door_open_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign elev_f_o    = cur_r;
  assign dir_o       = dir_r;
  assign door_open_o = door_open_r;
  assign busy_o      = busy_r;
  assign pend_o      = car_p_r | up_p_r | dn_p_r;

endmodule
